dcache_line_ctrl: RTL
=====================

Name: dcache_line_ctrl

Overview:
- Refill/writeback sequencer that sits directly upstream of the D-cache data array (16-word single-port distributed RAM, 4-bit word address, zero read latency).
- On a miss, it writes back the dirty victim line by streaming words out of the array onto the write bus.
- It then bursts the new line from the read bus and writes each returned word into the array.
- Reports completion to the cache pipeline with a one-cycle done pulse.

Parameters:
- WORDS_PER_LINE, 16, words per line; power of two; matches data array depth.
- IDX_WIDTH, 4, array word-address width = log2(WORDS_PER_LINE).
- PADDR_WIDTH, 32, physical address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- miss_valid  in  1  miss request.
- miss_ready  out  1  request accepted when both valid and ready are high.
- miss_dirty  in  1  victim line must be written back.
- miss_victim_addr  in  PADDR_WIDTH  victim address; offset bits ignored.
- miss_fill_addr  in  PADDR_WIDTH  missing address.
- done  out  1  one-cycle completion pulse.
- array_en  out  1  data array enable.
- array_addr  out  IDX_WIDTH  data array word index.
- array_strobe  out  1  data array write enable.
- array_wdata  out  32  data array write data.
- array_rdata  in  32  data array read data (combinational).
- wb_req  out  1  write-burst address request.
- wb_addr  out  PADDR_WIDTH  line-aligned victim address.
- wb_ack  in  1  write address accepted.
- wb_valid  out  1  write data valid.
- wb_data  out  32  write data.
- wb_last  out  1  final write beat.
- wb_ready  in  1  write beat accepted.
- wb_resp  in  1  write burst complete.
- rd_req  out  1  read-burst address request.
- rd_addr  out  PADDR_WIDTH  read burst start address.
- rd_ack  in  1  read address accepted.
- rd_valid  in  1  read beat valid (no backpressure).
- rd_data  in  32  read beat data.
- crit_valid  out  1  critical-word pulse (CWF build only; otherwise 0).
- crit_data  out  32  critical word.

Behaviour:
- FSM states: IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, DONE.
- Reset (asynchronous): state=IDLE, beat counter cnt=0, latched addresses=0. All outputs 0 except miss_ready=1.
- miss_ready=1 only in IDLE. A handshake latches both addresses, the dirty flag and the start offset.
  - Dirty miss: IDLE→WB_ADDR. Clean miss: IDLE→RD_ADDR.
  - miss_valid outside IDLE is ignored.
- WB_ADDR: wb_req=1 and wb_addr held. Advance to WB_DATA on wb_ack. cnt=0.
- WB_DATA:
  - Outputs: array_en=1, array_addr=cnt, wb_valid=1, wb_data=array_rdata (same cycle), wb_last=(cnt==WORDS_PER_LINE-1).
  - On wb_ready: cnt++. On a beat with wb_last → WB_RESP.
  - With wb_ready low: cnt and all outputs are held.
- WB_RESP: wait for wb_resp, then → RD_ADDR.
- RD_ADDR: rd_req=1. On rd_ack → RD_DATA with cnt=start offset (0 without CWF).
- RD_DATA:
  - array_en=1, array_addr=cnt, array_wdata=rd_data, array_strobe=rd_valid.
  - On each rd_valid: cnt wraps modulo WORDS_PER_LINE, and a beat counter increments.
  - After WORDS_PER_LINE beats → DONE.
  - Gaps in rd_valid stall without writing.
  - The controller counts beats itself; there is no rd_last.
- DONE: done=1 for exactly one cycle, then → IDLE (miss_ready=1 next cycle).
- Request outputs (wb_req, rd_req) stay high until acked, never dropping mid-handshake.
- array_strobe is never high outside RD_DATA. The controller never reads and writes the array in the same state.
- Reset asserted mid-operation: immediate return to IDLE. Partially filled line contents are undefined. The tag owner invalidates the line; no done is produced.
- Back-to-back misses: a new miss is accepted at the earliest on the cycle after done.

Optional Feature:
- Macro: DCACHE_CWF_EN.
- Defined (critical word first):
  - rd_addr = miss_fill_addr word-aligned, not line-aligned.
  - cnt starts at the fill word offset and wraps.
  - On the first RD_DATA beat, crit_valid=1 for one cycle with crit_data=rd_data.
- Undefined:
  - rd_addr line-aligned; cnt starts at 0.
  - crit_valid and crit_data are tied 0.

Test Plan:
- Clean miss, fill_addr=0x0000_1234; rd_valid every cycle with data 0xA0+i → rd_addr=0x0000_1200 (non-CWF); array word i written 0xA0+i; done exactly 1 cycle after 16th beat; no wb_req.
- Dirty miss, victim=0x0000_8040, array preloaded word i=0x100+i; wb_ready toggles 1,0,1,0 → wb_addr=0x0000_8040; 16 beats 0x100..0x10F in order; wb_last only on 0x10F; rd_req only after wb_resp.
- Fill with rd_valid gaps (valid on alternate cycles) → array_strobe only on valid cycles; 16 writes total; done after last.
- Reset asserted after 5 fill beats → next edge-independent return to IDLE; miss_ready=1; no done; new miss then completes normally.
- CWF build, fill_addr offset word 13 → rd_addr=0x…34 word-aligned; writes to indices 13,14,15,0..12; crit_valid pulses with first beat data.
- miss_valid held high across busy period → only one miss accepted per done; second accepted the cycle after done.

Source files
------------

// File: rtl/dcache_line_ctrl_if.sv
// Bus bundle between the D-cache line refill/writeback sequencer and its surroundings
// (cache pipeline, data array, write bus, read bus). master = sequencer, slave = environment.
interface dcache_line_ctrl_if #(
  parameter int IDX_WIDTH   = 4,
  parameter int PADDR_WIDTH = 32
);
  // Handshakes: a transfer happens on a rising clk edge where the source's valid/req and
  // the sink's ready/ack are both high; the source holds valid/req and its payload stable
  // until that edge. rd_valid has no backpressure, wb_resp and done are single-cycle pulses.
  logic                   miss_valid;
  logic                   miss_ready;
  logic                   miss_dirty;
  logic [PADDR_WIDTH-1:0] miss_victim_addr;
  logic [PADDR_WIDTH-1:0] miss_fill_addr;
  logic                   done;

  logic                   array_en;
  logic [IDX_WIDTH-1:0]   array_addr;
  logic                   array_strobe;
  logic [31:0]            array_wdata;
  logic [31:0]            array_rdata;

  logic                   wb_req;
  logic [PADDR_WIDTH-1:0] wb_addr;
  logic                   wb_ack;
  logic                   wb_valid;
  logic [31:0]            wb_data;
  logic                   wb_last;
  logic                   wb_ready;
  logic                   wb_resp;

  logic                   rd_req;
  logic [PADDR_WIDTH-1:0] rd_addr;
  logic                   rd_ack;
  logic                   rd_valid;
  logic [31:0]            rd_data;

  logic                   crit_valid;
  logic [31:0]            crit_data;

  modport master (
    input  miss_valid, miss_dirty, miss_victim_addr, miss_fill_addr,
    input  array_rdata, wb_ack, wb_ready, wb_resp, rd_ack, rd_valid, rd_data,
    output miss_ready, done, array_en, array_addr, array_strobe, array_wdata,
    output wb_req, wb_addr, wb_valid, wb_data, wb_last, rd_req, rd_addr,
    output crit_valid, crit_data
  );

  modport slave (
    output miss_valid, miss_dirty, miss_victim_addr, miss_fill_addr,
    output array_rdata, wb_ack, wb_ready, wb_resp, rd_ack, rd_valid, rd_data,
    input  miss_ready, done, array_en, array_addr, array_strobe, array_wdata,
    input  wb_req, wb_addr, wb_valid, wb_data, wb_last, rd_req, rd_addr,
    input  crit_valid, crit_data
  );
endinterface

// File: rtl/dcache_line_ctrl.sv
// D-cache line refill/writeback sequencer: streams a dirty victim line out, bursts the new line in.
// Define DCACHE_CWF_EN to build the critical-word-first variant (word-aligned fill, wrapping index).
module dcache_line_ctrl #(
  parameter int WORDS_PER_LINE = 16,
  parameter int IDX_WIDTH      = 4,
  parameter int PADDR_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  dcache_line_ctrl_if.master    bus,
  output logic [2:0]            dbg_state
);

  localparam int LINE_LSB = IDX_WIDTH + 2;
  localparam logic [PADDR_WIDTH-1:0] LINE_MASK = PADDR_WIDTH'((64'd1 << LINE_LSB) - 64'd1);
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(WORDS_PER_LINE - 1);
  localparam logic [IDX_WIDTH:0]     LAST_BEAT = (IDX_WIDTH + 1)'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_ADDR = 3'd1,
    WB_DATA = 3'd2,
    WB_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   cnt;
  logic [IDX_WIDTH:0]     beats;
  logic [PADDR_WIDTH-1:0] victim_q;
  logic [PADDR_WIDTH-1:0] fill_q;
  logic [IDX_WIDTH-1:0]   start_q;
  logic [IDX_WIDTH-1:0]   start_ofs;
  logic                   in_wb;
  logic                   in_rd;

`ifdef DCACHE_CWF_EN
  assign start_ofs      = bus.miss_fill_addr[LINE_LSB-1:2];
  assign bus.rd_addr    = fill_q & ~PADDR_WIDTH'(3);
  assign bus.crit_valid = in_rd && bus.rd_valid && (beats == '0);
  assign bus.crit_data  = bus.crit_valid ? bus.rd_data : 32'd0;
`else
  assign start_ofs      = '0;
  assign bus.rd_addr    = fill_q & ~LINE_MASK;
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = 32'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      beats    <= '0;
      victim_q <= '0;
      fill_q   <= '0;
      start_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_valid) begin
            victim_q <= bus.miss_victim_addr;
            fill_q   <= bus.miss_fill_addr;
            start_q  <= start_ofs;
            cnt      <= '0;
            beats    <= '0;
            state    <= bus.miss_dirty ? WB_ADDR : RD_ADDR;
          end
        end
        WB_ADDR: if (bus.wb_ack) state <= WB_DATA;
        WB_DATA: begin
          // cnt wraps back to 0 after the last beat, ready for a non-CWF fill.
          if (bus.wb_ready) begin
            cnt <= cnt + IDX_WIDTH'(1);
            if (cnt == LAST_IDX) state <= WB_RESP;
          end
        end
        WB_RESP: if (bus.wb_resp) state <= RD_ADDR;
        RD_ADDR: begin
          if (bus.rd_ack) begin
            cnt   <= start_q;
            beats <= '0;
            state <= RD_DATA;
          end
        end
        RD_DATA: begin
          // No rd_last on the bus: the line is complete after WORDS_PER_LINE counted beats.
          if (bus.rd_valid) begin
            cnt   <= cnt + IDX_WIDTH'(1);
            beats <= beats + (IDX_WIDTH + 1)'(1);
            if (beats == LAST_BEAT) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_wb = (state == WB_DATA);
  assign in_rd = (state == RD_DATA);

  assign bus.miss_ready   = (state == IDLE);
  assign bus.done         = (state == DONE);
  assign bus.wb_req       = (state == WB_ADDR);
  assign bus.rd_req       = (state == RD_ADDR);
  assign bus.wb_addr      = victim_q & ~LINE_MASK;

  // The array is read only while streaming the victim and written only while filling.
  assign bus.array_en     = in_wb || in_rd;
  assign bus.array_addr   = bus.array_en ? cnt : '0;
  assign bus.array_strobe = in_rd && bus.rd_valid;
  assign bus.array_wdata  = in_rd ? bus.rd_data : 32'd0;

  assign bus.wb_valid     = in_wb;
  assign bus.wb_data      = in_wb ? bus.array_rdata : 32'd0;
  assign bus.wb_last      = in_wb && (cnt == LAST_IDX);

  assign dbg_state        = state;

endmodule
